// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants and forwarding select encoding.
package cpu_pkg;
    localparam int DATA_W = 64;
    localparam int CTRL_MEMREAD = 0;
    localparam logic [4:0] XZR = 5'd31;
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_ALU = 2'b10
    } fwd_sel_t;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks regfile, MEM/WB or EX/MEM value; the reserved select falls back to regfile.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] rf,
    input  logic [W-1:0] mem,
    input  logic [W-1:0] alu,
    output logic [W-1:0] y
);
    assign y = (sel == FWD_ALU) ? alu : (sel == FWD_MEM) ? mem : rf;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX boundary with operand forwarding, load-use stall/bubble,
// branch flush, downstream hold and a saturating stall counter.
module id_ex_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_rm,
    input  logic [4:0]        id_rn,
    input  logic              id_uses_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    input  logic [DATA_W-1:0] rf_d,
    input  logic [DATA_W-1:0] alu_fwd,
    input  logic [DATA_W-1:0] mem_fwd,
    input  logic [1:0]        fa,
    input  logic [1:0]        fb,
    input  logic [1:0]        da,
    input  logic [1:0]        db,
    input  logic              flush,
    input  logic              hold_ex,
    output logic              stall_id,
    output logic [DATA_W-1:0] id_br_val,
    output logic              ex_valid,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_st,
    output logic [CNT_W-1:0]  stall_cnt
);
    import cpu_pkg::*;

    logic [DATA_W-1:0] op_a, op_b, op_st;
    logic              dep;

    fwd_mux #(.W(DATA_W)) u_mux_a  (.sel(fa), .rf(rf_a), .mem(mem_fwd), .alu(alu_fwd), .y(op_a));
    fwd_mux #(.W(DATA_W)) u_mux_b  (.sel(fb), .rf(rf_b), .mem(mem_fwd), .alu(alu_fwd), .y(op_b));
    fwd_mux #(.W(DATA_W)) u_mux_d  (.sel(da), .rf(rf_d), .mem(mem_fwd), .alu(alu_fwd), .y(op_st));
    fwd_mux #(.W(DATA_W)) u_mux_br (.sel(db), .rf(rf_d), .mem(mem_fwd), .alu(alu_fwd), .y(id_br_val));

    assign dep = (ex_rd == id_rm) || (ex_rd == id_rn) || (id_uses_rd && ex_rd == id_rd);
    // Upstream is frozen by the same wait as EX, so no stall is raised under hold.
    assign stall_id = !hold_ex && ex_valid && ex_ctrl[CTRL_MEMREAD] && ex_rd != XZR && id_valid && dep;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_rd     <= XZR;
            ex_ctrl   <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_st     <= '0;
            stall_cnt <= '0;
        end else if (flush || (!hold_ex && stall_id)) begin
            ex_valid <= 1'b0;
            ex_rd    <= XZR;
            ex_ctrl  <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_st    <= '0;
            if (!flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end else if (!hold_ex) begin
            ex_valid <= id_valid;
            ex_rd    <= id_rd;
            ex_ctrl  <= id_ctrl;
            ex_a     <= op_a;
            ex_b     <= op_b;
            ex_st    <= op_st;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors, corner sequences and random stimulus against a reference model.
module tb_id_ex_stage;
    localparam int DW = 64;
    localparam int CW = 16;
    localparam int NW = 4;

    logic          clk = 0;
    logic          reset, id_valid, id_uses_rd, flush, hold_ex;
    logic [4:0]    id_rd, id_rm, id_rn;
    logic [CW-1:0] id_ctrl;
    logic [DW-1:0] rf_a, rf_b, rf_d, alu_fwd, mem_fwd;
    logic [1:0]    fa, fb, da, db;
    logic          stall_id, ex_valid;
    logic [DW-1:0] id_br_val, ex_a, ex_b, ex_st;
    logic [4:0]    ex_rd;
    logic [CW-1:0] ex_ctrl;
    logic [NW-1:0] stall_cnt;

    id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd), .id_rm(id_rm),
        .id_rn(id_rn), .id_uses_rd(id_uses_rd), .id_ctrl(id_ctrl), .rf_a(rf_a), .rf_b(rf_b),
        .rf_d(rf_d), .alu_fwd(alu_fwd), .mem_fwd(mem_fwd), .fa(fa), .fb(fb), .da(da), .db(db),
        .flush(flush), .hold_ex(hold_ex), .stall_id(stall_id), .id_br_val(id_br_val),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
        .ex_st(ex_st), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the EX stage contents.
    logic          m_valid;
    logic [4:0]    m_rd;
    logic [CW-1:0] m_ctrl;
    logic [DW-1:0] m_a, m_b, m_st;
    int            m_cnt;

    typedef struct {
        logic [1:0]    fa, fb, da, db;
        logic [DW-1:0] rf_a, rf_b, rf_d, alu, mem;
        logic [DW-1:0] e_a, e_b, e_st, e_br;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] r,
                                           input logic [DW-1:0] m, input logic [DW-1:0] a);
        logic [DW-1:0] src[4];
        src = '{r, m, a, r};
        return src[sel];
    endfunction

    function automatic logic hazard();
        logic [4:0] srcs[$];
        srcs = {id_rm, id_rn};
        if (id_uses_rd) srcs.push_back(id_rd);
        return !hold_ex && id_valid && m_valid && m_ctrl[0] && m_rd != 5'd31 && (m_rd inside {srcs});
    endfunction

    task automatic model_clear(input logic clr_cnt);
        m_valid = 0; m_rd = 5'd31; m_ctrl = '0; m_a = '0; m_b = '0; m_st = '0;
        if (clr_cnt) m_cnt = 0;
    endtask

    task automatic cycle();
        logic h;
        #1;
        h = hazard();
        chk("stall_id", {63'd0, stall_id}, {63'd0, h});
        chk("id_br_val", id_br_val, pick(db, rf_d, mem_fwd, alu_fwd));
        if (reset) model_clear(1);
        else if (flush || h) begin
            if (!flush && m_cnt < (1 << NW) - 1) m_cnt++;
            model_clear(0);
        end else if (!hold_ex) begin
            m_valid = id_valid; m_rd = id_rd; m_ctrl = id_ctrl;
            m_a = pick(fa, rf_a, mem_fwd, alu_fwd);
            m_b = pick(fb, rf_b, mem_fwd, alu_fwd);
            m_st = pick(da, rf_d, mem_fwd, alu_fwd);
        end
        @(posedge clk);
        #1;
        chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
        chk("ex_rd", {59'd0, ex_rd}, {59'd0, m_rd});
        chk("ex_ctrl", {48'd0, ex_ctrl}, {48'd0, m_ctrl});
        chk("ex_a", ex_a, m_a);
        chk("ex_b", ex_b, m_b);
        chk("ex_st", ex_st, m_st);
        chk("stall_cnt", {60'd0, stall_cnt}, DW'(m_cnt));
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rm,
                          input logic [4:0] rn, input logic u, input logic [CW-1:0] c);
        id_valid = v; id_rd = rd; id_rm = rm; id_rn = rn; id_uses_rd = u; id_ctrl = c;
    endtask

    task automatic load_then_use(input logic [4:0] rd);
        set_id(1, rd, 5'd0, 5'd0, 0, 16'h0001);
        cycle();
        set_id(1, 5'd9, 5'd8, rd, 0, 16'h0000);
        cycle();
    endtask

    initial begin
        vecs[0] = '{2'd2, 2'd1, 2'd0, 2'd0, 64'h1, 64'h2, 64'h77, 64'h55, 64'h66,
                    64'h55, 64'h66, 64'h77, 64'h77};
        vecs[1] = '{2'd3, 2'd0, 2'd2, 2'd1, 64'h9, 64'h12, 64'h13, 64'hAA, 64'hBB,
                    64'h9, 64'h12, 64'hAA, 64'hBB};
        vecs[2] = '{2'd1, 2'd3, 2'd3, 2'd2, 64'h21, 64'h42, 64'h99, 64'h77, 64'h1234,
                    64'h1234, 64'h42, 64'h99, 64'h77};
        vecs[3] = '{2'd0, 2'd2, 2'd1, 2'd3, '1, 64'h3, 64'h8, 64'h5, 64'h6,
                    '1, 64'h5, 64'h6, 64'h8};

        reset = 1; flush = 0; hold_ex = 0;
        set_id(0, 0, 0, 0, 0, 0);
        fa = 0; fb = 0; da = 0; db = 0;
        rf_a = 0; rf_b = 0; rf_d = 0; alu_fwd = 0; mem_fwd = 0;
        repeat (2) @(posedge clk);
        #1;
        model_clear(1);
        chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_ex_rd", {59'd0, ex_rd}, 64'd31);
        chk("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        chk("rst_stall_id", {63'd0, stall_id}, 64'd0);
        reset = 0;

        foreach (vecs[i]) begin
            fa = vecs[i].fa; fb = vecs[i].fb; da = vecs[i].da; db = vecs[i].db;
            rf_a = vecs[i].rf_a; rf_b = vecs[i].rf_b; rf_d = vecs[i].rf_d;
            alu_fwd = vecs[i].alu; mem_fwd = vecs[i].mem;
            set_id(1, 5'd7, 5'd1, 5'd2, 0, 16'h00F0);
            #1;
            chk("vec_br", id_br_val, vecs[i].e_br);
            cycle();
            chk("vec_a", ex_a, vecs[i].e_a);
            chk("vec_b", ex_b, vecs[i].e_b);
            chk("vec_st", ex_st, vecs[i].e_st);
            chk("vec_valid", {63'd0, ex_valid}, 64'd1);
        end

        // Load-use: one stall cycle then the dependent instruction latches.
        set_id(1, 5'd3, 5'd0, 5'd0, 0, 16'h0001);
        cycle();
        set_id(1, 5'd4, 5'd1, 5'd3, 0, 16'h0000);
        #1;
        chk("lu_stall", {63'd0, stall_id}, 64'd1);
        cycle();
        chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
        chk("lu_cnt", {60'd0, stall_cnt}, 64'd1);
        #1;
        chk("lu_release", {63'd0, stall_id}, 64'd0);
        cycle();
        chk("lu_latched", {59'd0, ex_rd}, 64'd4);

        // XZR destination never stalls; a store reading rd does.
        set_id(1, 5'd31, 5'd0, 5'd0, 0, 16'h0001);
        cycle();
        set_id(1, 5'd31, 5'd31, 5'd31, 1, 16'h0000);
        #1;
        chk("xzr_nostall", {63'd0, stall_id}, 64'd0);
        cycle();
        set_id(1, 5'd5, 5'd0, 5'd0, 0, 16'h0001);
        cycle();
        set_id(1, 5'd5, 5'd1, 5'd2, 1, 16'h0000);
        #1;
        chk("stur_stall", {63'd0, stall_id}, 64'd1);
        cycle();
        set_id(0, 5'd5, 5'd5, 5'd5, 1, 16'h0001);
        cycle();
        chk("invalid_latched", {63'd0, ex_valid}, 64'd0);

        // Flush beats stall: bubble without counting.
        set_id(1, 5'd3, 5'd0, 5'd0, 0, 16'h0001);
        cycle();
        set_id(1, 5'd4, 5'd3, 5'd1, 0, 16'h0000);
        flush = 1;
        cycle();
        flush = 0;
        chk("flush_cnt", {60'd0, stall_cnt}, 64'd2);
        chk("flush_bubble", {63'd0, ex_valid}, 64'd0);

        // Hold freezes EX and suppresses the stall until it drops.
        set_id(1, 5'd6, 5'd0, 5'd0, 0, 16'h0001);
        cycle();
        set_id(1, 5'd7, 5'd6, 5'd1, 0, 16'h0000);
        hold_ex = 1;
        repeat (3) cycle();
        chk("hold_rd", {59'd0, ex_rd}, 64'd6);
        hold_ex = 0;
        #1;
        chk("hold_then_stall", {63'd0, stall_id}, 64'd1);
        cycle();
        cycle();

        // Saturation of the stall counter.
        for (int k = 0; k < 16; k++) load_then_use(5'd2);
        chk("cnt_sat", {60'd0, stall_cnt}, 64'd15);

        // Reset in the middle of a stall.
        set_id(1, 5'd3, 5'd0, 5'd0, 0, 16'h0001);
        cycle();
        set_id(1, 5'd4, 5'd3, 5'd3, 0, 16'h0000);
        reset = 1;
        cycle();
        reset = 0;
        chk("rst_mid_cnt", {60'd0, stall_cnt}, 64'd0);
        #1;
        chk("rst_mid_stall", {63'd0, stall_id}, 64'd0);

        for (int n = 0; n < 1500; n++) begin
            logic [4:0] r[3];
            foreach (r[j]) begin
                int p;
                p = $urandom_range(0, 4);
                r[j] = (p == 4) ? 5'd31 : 5'(p);
            end
            set_id(1'($urandom_range(0, 7) != 0), r[0], r[1], r[2], 1'($urandom), 16'($urandom));
            fa = 2'($urandom); fb = 2'($urandom); da = 2'($urandom); db = 2'($urandom);
            rf_a = {$urandom, $urandom}; rf_b = {$urandom, $urandom}; rf_d = {$urandom, $urandom};
            alu_fwd = {$urandom, $urandom}; mem_fwd = {$urandom, $urandom};
            flush = ($urandom_range(0, 9) == 0);
            hold_ex = ($urandom_range(0, 6) == 0);
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
